// File: rtl/mux4way_arbiter_pkg.sv
// Shared constants for the 4-way round-robin merge arbiter.
// The select encoding matches the downstream DMux4Way fan-out.
package mux4way_arbiter_pkg;

    localparam int NUM_CH = 4;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    // Reset value of last: makes channel a the first in line after reset.
    localparam logic [1:0] LAST_RST = SEL_D;

    function automatic logic [NUM_CH-1:0] sel_onehot(input logic [1:0] sel);
        logic [NUM_CH-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux4way_arbiter_rr_pick4.sv
// Rotating priority encoder: scans last+1, last+2, last+3, last (mod 4)
// and returns the first requesting index.
module rr_pick4
    import mux4way_arbiter_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [1:0]        last,
    output logic              any,
    output logic [1:0]        idx
);

    logic [1:0] cand;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no
        // path through the block leaves it unassigned and no latch is inferred.
        any  = |req;
        idx  = last;
        cand = last;
        // Walk from lowest priority to highest so the closest hit wins.
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = last + 2'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux4way_arbiter.sv
// Merges four valid/ready channels into one registered stream, round-robin,
// tagging each word with its source select.
module mux4way_arbiter
    import mux4way_arbiter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         in_valid,
    input  logic [NUM_CH*WIDTH-1:0]   in_data,
    output logic [NUM_CH-1:0]         in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [1:0]                out_sel
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [1:0]       out_sel_q,   out_sel_d;
    logic [1:0]       last_q,      last_d;

    logic             load;
    logic             any;
    logic [1:0]       idx;
    logic [WIDTH-1:0] ch_data [NUM_CH];

    rr_pick4 u_pick (
        .req  (in_valid),
        .last (last_q),
        .any  (any),
        .idx  (idx)
    );

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_data[i] = in_data[i*WIDTH +: WIDTH];
        end
    end

    // The output register can take a word when empty or when it is being popped.
    assign load = !out_valid_q || out_ready;

    always_comb begin
        in_ready = '0;
        if (rst_n && load && any) begin
            in_ready = sel_onehot(idx);
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        last_d      = last_q;
        if (load) begin
            out_valid_d = any;
            if (any) begin
                out_data_d = ch_data[idx];
                out_sel_d  = idx;
                last_d     = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from the
        // same pre-edge values regardless of statement order.
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= SEL_A;
            last_q      <= LAST_RST;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux4way_arbiter.sv
// Self-checking bench for mux4way_arbiter: directed scenarios then random
// traffic, all compared against a behavioural round-robin model.
module tb_mux4way_arbiter;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     in_valid;
    logic [4*W-1:0] in_data;
    logic [3:0]     in_ready;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_sel;
    int           m_last;
    logic [3:0]   ir_seen;

    mux4way_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // First channel with valid set, scanning forward from the one after last.
    function automatic int pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (v[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    // One clock: drive at the falling edge, check in_ready just after,
    // advance the model at the rising edge, check outputs at the next fall.
    task automatic cycle(input logic rstn, input logic [3:0] v,
                         input logic [4*W-1:0] d, input logic ordy);
        int g;
        logic [3:0] exp_ready;
        bit   ld;
        rst_n     = rstn;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        ld        = !m_valid || ordy;
        g         = pick(v, m_last);
        exp_ready = (rstn && ld && g >= 0) ? 4'(1 << g) : 4'b0000;
        ir_seen   = in_ready;
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        @(posedge clk);
        if (!rstn) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_sel   = 0;
            m_last  = 3;
        end else if (ld) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = d[g*W +: W];
                m_sel   = g;
                m_last  = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("out_sel",   32'(out_sel),   32'(m_sel));
    endtask

    function automatic logic [4*W-1:0] pack(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] c, input logic [W-1:0] d);
        return {d, c, b, a};
    endfunction

    initial begin
        logic [4*W-1:0] consts;
        logic [4*W-1:0] rnd;
        consts    = pack(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        rst_n     = 1'b0;
        in_valid  = 4'hF;
        in_data   = consts;
        out_ready = 1'b0;
        m_valid   = 1'b0;
        m_data    = '0;
        m_sel     = 0;
        m_last    = 3;
        @(negedge clk);

        // Reset held two cycles with every channel requesting
        repeat (2) begin
            cycle(1'b0, 4'hF, consts, 1'b1);
            chk("rst_ready", 32'(ir_seen), 32'h0);
        end
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data",  32'(out_data),  32'h0);
        chk("rst_sel",   32'(out_sel),   32'h0);

        // All four valid: strict rotation a,b,c,d,a,b,c,d
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 4'hF, consts, 1'b1);
            chk("rr_ready", 32'(ir_seen),  32'(1 << (i % 4)));
            chk("rr_sel",   32'(out_sel),  32'(i % 4));
            chk("rr_data",  32'(out_data), 32'(((i % 4) + 1) * 32'h1111));
            chk("rr_valid", 32'(out_valid), 32'h1);
        end

        // Sparse wrap after d: a then c
        cycle(1'b1, 4'b0101, consts, 1'b1);
        chk("wrap_a", 32'(out_sel), 32'h0);
        cycle(1'b1, 4'b0101, consts, 1'b1);
        chk("wrap_c", 32'(out_sel), 32'h2);

        // Backpressure with only b valid
        cycle(1'b1, 4'b0010, pack(16'h0, 16'hBEEF, 16'h0, 16'h0), 1'b1);
        repeat (3) begin
            cycle(1'b1, 4'b0010, pack(16'h0, 16'hBEEF, 16'h0, 16'h0), 1'b0);
            chk("stall_ready", 32'(ir_seen),  32'h0);
            chk("stall_data",  32'(out_data), 32'hBEEF);
            chk("stall_sel",   32'(out_sel),  32'h1);
        end
        cycle(1'b1, 4'b0000, '0, 1'b1);
        chk("bp_drained", 32'(out_valid), 32'h0);

        // Idle drain after one word from c
        cycle(1'b1, 4'b0100, pack(16'h0, 16'h0, 16'h00C0, 16'h0), 1'b1);
        chk("drain_word", 32'(out_data), 32'h00C0);
        cycle(1'b1, 4'b0000, '0, 1'b1);
        chk("drain_valid", 32'(out_valid), 32'h0);
        chk("drain_hold",  32'(out_data),  32'h00C0);

        // Reset while a word is stalled; a must beat d afterwards
        cycle(1'b1, 4'b0010, pack(16'h0, 16'h5A5A, 16'h0, 16'h0), 1'b1);
        cycle(1'b0, 4'b1001, consts, 1'b0);
        chk("midrst_valid", 32'(out_valid), 32'h0);
        cycle(1'b1, 4'b1001, consts, 1'b1);
        chk("midrst_ready", 32'(ir_seen), 32'h1);
        chk("midrst_sel",   32'(out_sel), 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rnd = {$urandom, $urandom};
            cycle(($urandom_range(0, 29) != 0), 4'($urandom), rnd,
                  ($urandom_range(0, 9) < 7));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
